// File: rtl/reduce_check.sv
// reduce_check: checks the six reduction flags sent with each 4-bit word and reports a per-flag
// mismatch mask through a 2-stage valid/ready pipeline. Counters exist only with REDUCE_CHK_CNT_EN.
module reduce_check #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_vec,
    input  logic [5:0]       in_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_vec,
    output logic [5:0]       out_err_mask,
    output logic             out_err,
    input  logic             clr_err,
    output logic             err_sticky
`ifdef REDUCE_CHK_CNT_EN
    ,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
`endif
);
    logic       s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [3:0] s1_vec_q, s1_vec_d, s2_vec_q, s2_vec_d;
    logic [5:0] s1_flags_q, s1_flags_d, s2_mask_q, s2_mask_d;
    logic       s2_err_q, s2_err_d, sticky_q, sticky_d;
    logic       s1_adv, s2_adv, out_xfer;
    logic [5:0] s1_exp, s1_mask;

    always_comb begin
        s2_adv     = !s2_valid_q || out_ready;
        s1_adv     = !s1_valid_q || s2_adv;
        out_xfer   = s2_valid_q && out_ready;
        s1_exp     = {~^s1_vec_q, ~|s1_vec_q, ~&s1_vec_q, ^s1_vec_q, |s1_vec_q, &s1_vec_q};
        s1_mask    = s1_exp ^ s1_flags_q;
        s1_valid_d = s1_adv ? in_valid : s1_valid_q;
        s1_vec_d   = (s1_adv && in_valid) ? in_vec : s1_vec_q;
        s1_flags_d = (s1_adv && in_valid) ? in_flags : s1_flags_q;
        s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
        s2_vec_d   = (s2_adv && s1_valid_q) ? s1_vec_q : s2_vec_q;
        s2_mask_d  = (s2_adv && s1_valid_q) ? s1_mask : s2_mask_q;
        s2_err_d   = (s2_adv && s1_valid_q) ? |s1_mask : s2_err_q;
        // an error landing in the same cycle as a clear must survive it
        sticky_d   = (out_xfer && s2_err_q) || (!clr_err && sticky_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_vec_q   <= '0;
            s1_flags_q <= '0;
            s2_vec_q   <= '0;
            s2_mask_q  <= '0;
            s2_err_q   <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_vec_q   <= s1_vec_d;
            s1_flags_q <= s1_flags_d;
            s2_vec_q   <= s2_vec_d;
            s2_mask_q  <= s2_mask_d;
            s2_err_q   <= s2_err_d;
            sticky_q   <= sticky_d;
        end
    end

    assign in_ready     = s1_adv;
    assign out_valid    = s2_valid_q;
    assign out_vec      = s2_vec_q;
    assign out_err_mask = s2_mask_q;
    assign out_err      = s2_err_q;
    assign err_sticky   = sticky_q;

`ifdef REDUCE_CHK_CNT_EN
    logic [CNT_W-1:0] frame_q, frame_d, errc_q, errc_d, frame_base, errc_base;

    // clear first, then apply this cycle's increment so a coincident transfer counts as 1
    always_comb begin
        frame_base = clr_err ? '0 : frame_q;
        errc_base  = clr_err ? '0 : errc_q;
        frame_d    = (out_xfer && frame_base != '1) ? frame_base + CNT_W'(1) : frame_base;
        errc_d     = (out_xfer && s2_err_q && errc_base != '1) ? errc_base + CNT_W'(1) : errc_base;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q <= '0;
            errc_q  <= '0;
        end else begin
            frame_q <= frame_d;
            errc_q  <= errc_d;
        end
    end

    assign frame_cnt = frame_q;
    assign err_cnt   = errc_q;
`endif
endmodule

// File: tb/tb_reduce_check.sv
// tb_reduce_check: directed and random stimulus against a queue-based reference model of reduce_check.
module tb_reduce_check;
`ifdef REDUCE_CHK_CNT_EN
    localparam int CW = 2;
`else
    localparam int CW = 8;
`endif
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0, rst = 1'b1;
    logic          in_valid = 1'b0, out_ready = 1'b0, clr_err = 1'b0;
    logic [3:0]    in_vec = '0;
    logic [5:0]    in_flags = '0;
    logic          in_ready, out_valid, out_err, err_sticky;
    logic [3:0]    out_vec;
    logic [5:0]    out_err_mask;
`ifdef REDUCE_CHK_CNT_EN
    logic [CW-1:0] frame_cnt, err_cnt;
`endif

    always #5 clk = ~clk;

    reduce_check #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec), .in_flags(in_flags),
        .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
        .out_err_mask(out_err_mask), .out_err(out_err),
        .clr_err(clr_err), .err_sticky(err_sticky)
`ifdef REDUCE_CHK_CNT_EN
        , .frame_cnt(frame_cnt), .err_cnt(err_cnt)
`endif
    );

    typedef struct {
        logic [3:0] vec;
        logic [5:0] mask;
        int         acc_edge;
    } item_t;

    item_t q[$];
    int    edges = 0, checks = 0, failures = 0;
    int    m_fcnt = 0, m_ecnt = 0;
    logic  m_sticky = 1'b0;

    // expected flags from the popcount of the word, XORed with what was received
    function automatic logic [5:0] ref_mask(logic [3:0] v, logic [5:0] f);
        int   ones = $countones(v);
        logic a = (ones == 4);
        logic o = (ones != 0);
        logic x = (ones % 2) == 1;
        return {!x, !o, !a, x, o, a} ^ f;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic iv, input logic [3:0] v, input logic [5:0] f,
                        input logic ordy, input logic clr, output logic acc);
        logic  mv, mr, xfer;
        item_t it;
        @(negedge clk);
        in_valid = iv; in_vec = v; in_flags = f; out_ready = ordy; clr_err = clr;
        #1;
        mv = q.size() > 0 && q[0].acc_edge < edges;
        mr = q.size() < 2 || ordy;
        check("in_ready", 32'(in_ready), 32'(mr));
        check("out_valid", 32'(out_valid), 32'(mv));
        if (mv) begin
            check("out_vec", 32'(out_vec), 32'(q[0].vec));
            check("out_err_mask", 32'(out_err_mask), 32'(q[0].mask));
            check("out_err", 32'(out_err), 32'(|q[0].mask));
        end
        check("err_sticky", 32'(err_sticky), 32'(m_sticky));
`ifdef REDUCE_CHK_CNT_EN
        check("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
        check("err_cnt", 32'(err_cnt), 32'(m_ecnt));
`endif
        acc  = iv && mr;
        xfer = mv && ordy;
        @(posedge clk);
        edges++;
        if (clr) begin
            m_sticky = 1'b0; m_fcnt = 0; m_ecnt = 0;
        end
        if (xfer) begin
            it = q.pop_front();
            if (m_fcnt < CMAX) m_fcnt++;
            if (|it.mask) begin
                m_sticky = 1'b1;
                if (m_ecnt < CMAX) m_ecnt++;
            end
        end
        if (acc) q.push_back(item_t'{v, ref_mask(v, f), edges});
    endtask

    task automatic reset_dut();
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; clr_err = 1'b0; rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_vec", 32'(out_vec), 32'd0);
        check("rst_out_err_mask", 32'(out_err_mask), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_err_sticky", 32'(err_sticky), 32'd0);
`ifdef REDUCE_CHK_CNT_EN
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
        q.delete();
        m_sticky = 1'b0; m_fcnt = 0; m_ecnt = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic       a;
        logic [3:0] words[4];
        logic [3:0] v;
        logic [5:0] f;
        int         w;
        reset_dut();
        step(1'b1, 4'b1011, 6'b001110, 1'b1, 1'b0, a);
        step(1'b1, 4'b1111, 6'b100011, 1'b1, 1'b0, a);
        step(1'b1, 4'b0000, 6'b111000, 1'b1, 1'b0, a);
        repeat (3) step(1'b0, 4'h0, 6'h00, 1'b1, 1'b0, a);
        check("clean_sticky", 32'(err_sticky), 32'd0);
`ifdef REDUCE_CHK_CNT_EN
        check("clean_frames", 32'(frame_cnt), 32'd3);
`endif
        step(1'b1, 4'b1011, 6'b001010, 1'b1, 1'b0, a);
        step(1'b0, 4'h0, 6'h00, 1'b1, 1'b0, a);
        #2;
        check("single_mask", 32'(out_err_mask), 32'h04);
        step(1'b0, 4'h0, 6'h00, 1'b1, 1'b0, a);
        step(1'b0, 4'h0, 6'h00, 1'b1, 1'b0, a);
        check("single_sticky", 32'(err_sticky), 32'd1);
        for (int i = 0; i < 4; i++) words[i] = 4'($urandom_range(0, 15));
        w = 0;
        for (int i = 0; i < 5; i++) begin
            step(w < 4, words[w % 4], ref_mask(words[w % 4], 6'h00), 1'b0, 1'b0, a);
            if (a) w++;
        end
        check("bp_accepted", 32'(w), 32'd2);
        for (int i = 0; i < 20 && (w < 4 || q.size() > 0); i++) begin
            step(w < 4, words[w % 4], ref_mask(words[w % 4], 6'h00), 1'b1, 1'b0, a);
            if (a) w++;
        end
        check("bp_drained", 32'(q.size()), 32'd0);
        step(1'b1, 4'b1011, 6'b001010, 1'b1, 1'b0, a);
        step(1'b0, 4'h0, 6'h00, 1'b1, 1'b0, a);
        step(1'b0, 4'h0, 6'h00, 1'b1, 1'b1, a);
        step(1'b0, 4'h0, 6'h00, 1'b1, 1'b0, a);
        check("collide_sticky", 32'(err_sticky), 32'd1);
        step(1'b0, 4'h0, 6'h00, 1'b1, 1'b1, a);
        step(1'b0, 4'h0, 6'h00, 1'b1, 1'b0, a);
        check("clear_sticky", 32'(err_sticky), 32'd0);
        for (int i = 0; i < 5; i++) step(1'b1, 4'(i), ~ref_mask(4'(i), 6'h00), 1'b1, 1'b0, a);
        repeat (3) step(1'b0, 4'h0, 6'h00, 1'b1, 1'b0, a);
        repeat (4) step(1'b1, 4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)), 1'b0, 1'b0, a);
        reset_dut();
        for (int i = 0; i < 600; i++) begin
            v = 4'($urandom_range(0, 15));
            f = ref_mask(v, 6'h00) ^ (($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 63)) : 6'h00);
            step($urandom_range(0, 3) != 0, v, f, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0, a);
            if (i == 300) reset_dut();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
